// File: rtl/axi4_rr_arbiter_if.sv
// AXI4 channel bundle (AR/R/AW/W/B) for the 2:1 round-robin arbiter.
// The master modport drives requests; the slave modport drives responses.
interface axi4_rr_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
);
   logic                  arvalid, arready;
   logic [ID_W-1:0]       arid;
   logic [ADDR_W-1:0]     araddr;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  rvalid, rready, rlast;
   logic [ID_W-1:0]       rid;
   logic [DATA_W-1:0]     rdata;
   logic [1:0]            rresp;
   logic                  awvalid, awready;
   logic [ID_W-1:0]       awid;
   logic [ADDR_W-1:0]     awaddr;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic                  wvalid, wready, wlast;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic                  bvalid, bready;
   logic [ID_W-1:0]       bid;
   logic [1:0]            bresp;

   modport master (
      output arvalid, arid, araddr, arlen, arsize, arburst, rready,
             awvalid, awid, awaddr, awlen, awsize, awburst,
             wvalid, wdata, wstrb, wlast, bready,
      input  arready, rvalid, rid, rdata, rresp, rlast,
             awready, wready, bvalid, bid, bresp
   );

   modport slave (
      input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
             awvalid, awid, awaddr, awlen, awsize, awburst,
             wvalid, wdata, wstrb, wlast, bready,
      output arready, rvalid, rid, rdata, rresp, rlast,
             awready, wready, bvalid, bid, bresp
   );
endinterface

// File: rtl/axi4_rr_arbiter.sv
// 2:1 AXI4 round-robin arbiter (m0 = IFU, m1 = LSU) with independent read/write paths.
// Optional macro AXI4_ARB_ID_TAG_EN: tag outgoing ID MSB with master index, route R/B by ID MSB.
//
//  state  | meaning
//  R_IDLE | no read in flight, arbitrate AR requests
//  R_ADDR | AR of granted master forwarded
//  R_DATA | R beats routed to granted master until rlast
//  W_IDLE | no write in flight, arbitrate AW requests
//  W_XFER | AW and W bursts of granted master forwarded
//  W_RESP | B routed to granted master
module axi4_rr_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic            clock,
   input  logic            reset_n,
   axi4_rr_arbiter_if.slave  m0,
   axi4_rr_arbiter_if.slave  m1,
   axi4_rr_arbiter_if.master out
);
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;
   typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wstate_e;

   rstate_e rstate_q, rstate_d;
   wstate_e wstate_q, wstate_d;
   logic    rgnt_q, rgnt_d, rd_last_q, rd_last_d;
   logic    wgnt_q, wgnt_d, wr_last_q, wr_last_d;
   logic    aw_done_q, aw_done_d, w_done_q, w_done_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rstate_q  <= R_IDLE;
         rgnt_q    <= 1'b0;
         rd_last_q <= 1'b1;
         wstate_q  <= W_IDLE;
         wgnt_q    <= 1'b0;
         wr_last_q <= 1'b1;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         rstate_q  <= rstate_d;
         rgnt_q    <= rgnt_d;
         rd_last_q <= rd_last_d;
         wstate_q  <= wstate_d;
         wgnt_q    <= wgnt_d;
         wr_last_q <= wr_last_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   always_comb begin
      rstate_d  = rstate_q;
      rgnt_d    = rgnt_q;
      rd_last_d = rd_last_q;
      case (rstate_q)
         R_IDLE: if (m0.arvalid | m1.arvalid) begin
            rgnt_d   = (m0.arvalid & m1.arvalid) ? ~rd_last_q : m1.arvalid;
            rstate_d = R_ADDR;
         end
         R_ADDR: if (out.arvalid & out.arready) rstate_d = R_DATA;
         R_DATA: if (out.rvalid & out.rready & out.rlast) begin
            rstate_d  = R_IDLE;
            rd_last_d = rgnt_q;
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   always_comb begin
      wstate_d  = wstate_q;
      wgnt_d    = wgnt_q;
      wr_last_d = wr_last_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      case (wstate_q)
         W_IDLE: if (m0.awvalid | m1.awvalid) begin
            wgnt_d   = (m0.awvalid & m1.awvalid) ? ~wr_last_q : m1.awvalid;
            wstate_d = W_XFER;
         end
         W_XFER: begin
            aw_done_d = aw_done_q | (out.awvalid & out.awready);
            w_done_d  = w_done_q | (out.wvalid & out.wready & out.wlast);
            if (aw_done_d & w_done_d) wstate_d = W_RESP;
         end
         W_RESP: if (out.bvalid & out.bready) begin
            wstate_d  = W_IDLE;
            wr_last_d = wgnt_q;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   // AR: forward granted master only while in R_ADDR
   logic              ar_act;
   logic [ID_W-1:0]   ar_id_sel, ar_id_out;
   logic [ADDR_W-1:0] ar_addr_sel;
   assign ar_act      = (rstate_q == R_ADDR);
   assign ar_id_sel   = rgnt_q ? m1.arid : m0.arid;
   assign ar_addr_sel = rgnt_q ? m1.araddr : m0.araddr;
`ifdef AXI4_ARB_ID_TAG_EN
   assign ar_id_out   = {rgnt_q, ar_id_sel[ID_W-2:0]};
`else
   assign ar_id_out   = ar_id_sel;
`endif
   assign out.arvalid = ar_act & (rgnt_q ? m1.arvalid : m0.arvalid);
   assign out.arid    = ar_act ? ar_id_out : '0;
   assign out.araddr  = ar_act ? ar_addr_sel : '0;
   assign out.arlen   = ar_act ? (rgnt_q ? m1.arlen : m0.arlen) : '0;
   assign out.arsize  = ar_act ? (rgnt_q ? m1.arsize : m0.arsize) : '0;
   assign out.arburst = ar_act ? (rgnt_q ? m1.arburst : m0.arburst) : '0;
   assign m0.arready  = ar_act & ~rgnt_q & out.arready;
   assign m1.arready  = ar_act &  rgnt_q & out.arready;

   // R: tagged builds steer by the returned ID MSB instead of the grant register
   logic            r_act, r_sel, r0, r1;
   logic [ID_W-1:0] r_id_ret;
   assign r_act = (rstate_q == R_DATA);
`ifdef AXI4_ARB_ID_TAG_EN
   assign r_sel    = out.rid[ID_W-1];
   assign r_id_ret = {1'b0, out.rid[ID_W-2:0]};
`else
   assign r_sel    = rgnt_q;
   assign r_id_ret = out.rid;
`endif
   assign r0 = r_act & ~r_sel;
   assign r1 = r_act &  r_sel;
   assign m0.rvalid  = r0 & out.rvalid;
   assign m0.rlast   = r0 & out.rlast;
   assign m0.rid     = r0 ? r_id_ret  : '0;
   assign m0.rdata   = r0 ? out.rdata : '0;
   assign m0.rresp   = r0 ? out.rresp : '0;
   assign m1.rvalid  = r1 & out.rvalid;
   assign m1.rlast   = r1 & out.rlast;
   assign m1.rid     = r1 ? r_id_ret  : '0;
   assign m1.rdata   = r1 ? out.rdata : '0;
   assign m1.rresp   = r1 ? out.rresp : '0;
   assign out.rready = r_act & (r_sel ? m1.rready : m0.rready);

   // AW / W: each channel drops out once its own half of the burst has completed
   logic              aw_act, w_act;
   logic [ID_W-1:0]   aw_id_sel, aw_id_out;
   logic [DATA_W-1:0] w_data_sel;
   assign aw_act     = (wstate_q == W_XFER) & ~aw_done_q;
   assign w_act      = (wstate_q == W_XFER) & ~w_done_q;
   assign aw_id_sel  = wgnt_q ? m1.awid : m0.awid;
   assign w_data_sel = wgnt_q ? m1.wdata : m0.wdata;
`ifdef AXI4_ARB_ID_TAG_EN
   assign aw_id_out  = {wgnt_q, aw_id_sel[ID_W-2:0]};
`else
   assign aw_id_out  = aw_id_sel;
`endif
   assign out.awvalid = aw_act & (wgnt_q ? m1.awvalid : m0.awvalid);
   assign out.awid    = aw_act ? aw_id_out : '0;
   assign out.awaddr  = aw_act ? (wgnt_q ? m1.awaddr : m0.awaddr) : '0;
   assign out.awlen   = aw_act ? (wgnt_q ? m1.awlen : m0.awlen) : '0;
   assign out.awsize  = aw_act ? (wgnt_q ? m1.awsize : m0.awsize) : '0;
   assign out.awburst = aw_act ? (wgnt_q ? m1.awburst : m0.awburst) : '0;
   assign m0.awready  = aw_act & ~wgnt_q & out.awready;
   assign m1.awready  = aw_act &  wgnt_q & out.awready;
   assign out.wvalid  = w_act & (wgnt_q ? m1.wvalid : m0.wvalid);
   assign out.wdata   = w_act ? w_data_sel : '0;
   assign out.wstrb   = w_act ? (wgnt_q ? m1.wstrb : m0.wstrb) : '0;
   assign out.wlast   = w_act & (wgnt_q ? m1.wlast : m0.wlast);
   assign m0.wready   = w_act & ~wgnt_q & out.wready;
   assign m1.wready   = w_act &  wgnt_q & out.wready;

   logic            b_act, b_sel, b0, b1;
   logic [ID_W-1:0] b_id_ret;
   assign b_act = (wstate_q == W_RESP);
`ifdef AXI4_ARB_ID_TAG_EN
   assign b_sel    = out.bid[ID_W-1];
   assign b_id_ret = {1'b0, out.bid[ID_W-2:0]};
`else
   assign b_sel    = wgnt_q;
   assign b_id_ret = out.bid;
`endif
   assign b0 = b_act & ~b_sel;
   assign b1 = b_act &  b_sel;
   assign m0.bvalid  = b0 & out.bvalid;
   assign m0.bid     = b0 ? b_id_ret  : '0;
   assign m0.bresp   = b0 ? out.bresp : '0;
   assign m1.bvalid  = b1 & out.bvalid;
   assign m1.bid     = b1 ? b_id_ret  : '0;
   assign m1.bresp   = b1 ? out.bresp : '0;
   assign out.bready = b_act & (b_sel ? m1.bready : m0.bready);
endmodule

// File: tb/tb_axi4_rr_arbiter.sv
// Directed self-checking bench for axi4_rr_arbiter; the bench plays both masters and the slave.
module tb_axi4_rr_arbiter;
   logic clock = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   axi4_rr_arbiter_if m0_if ();
   axi4_rr_arbiter_if m1_if ();
   axi4_rr_arbiter_if out_if ();

   axi4_rr_arbiter dut (
      .clock   (clock),
      .reset_n (reset_n),
      .m0      (m0_if),
      .m1      (m1_if),
      .out     (out_if)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one edge, then sit 1ns after it
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      m0_if.arvalid = 0; m0_if.arid = 0; m0_if.araddr = 0; m0_if.arlen = 0; m0_if.arsize = 3'd2; m0_if.arburst = 2'd1;
      m0_if.rready = 0;
      m0_if.awvalid = 0; m0_if.awid = 0; m0_if.awaddr = 0; m0_if.awlen = 0; m0_if.awsize = 3'd2; m0_if.awburst = 2'd1;
      m0_if.wvalid = 0; m0_if.wdata = 0; m0_if.wstrb = 4'hF; m0_if.wlast = 0; m0_if.bready = 0;
      m1_if.arvalid = 0; m1_if.arid = 0; m1_if.araddr = 0; m1_if.arlen = 0; m1_if.arsize = 3'd2; m1_if.arburst = 2'd1;
      m1_if.rready = 0;
      m1_if.awvalid = 0; m1_if.awid = 0; m1_if.awaddr = 0; m1_if.awlen = 0; m1_if.awsize = 3'd2; m1_if.awburst = 2'd1;
      m1_if.wvalid = 0; m1_if.wdata = 0; m1_if.wstrb = 4'hF; m1_if.wlast = 0; m1_if.bready = 0;
      out_if.arready = 0; out_if.rvalid = 0; out_if.rid = 0; out_if.rdata = 0; out_if.rresp = 0; out_if.rlast = 0;
      out_if.awready = 0; out_if.wready = 0; out_if.bvalid = 0; out_if.bid = 0; out_if.bresp = 0;

      step();
      chk("rst_out_arvalid", out_if.arvalid, 0);
      chk("rst_out_awvalid", out_if.awvalid, 0);
      chk("rst_out_rready", out_if.rready, 0);
      chk("rst_out_araddr", out_if.araddr, 0);
      step();
      reset_n = 1'b1;
      step();

      // T2: m0 single-beat read
      m0_if.arvalid = 1; m0_if.araddr = 32'h2000_0000; m0_if.arlen = 0; m0_if.arid = 4'h1;
      settle();
      chk("t2_idle_no_arvalid", out_if.arvalid, 0);
      step();
      chk("t2_out_arvalid", out_if.arvalid, 1);
      chk("t2_out_araddr", out_if.araddr, 32'h2000_0000);
      out_if.arready = 1;
      settle();
      chk("t2_m0_arready", m0_if.arready, 1);
      chk("t2_m1_arready", m1_if.arready, 0);
      step();
      m0_if.arvalid = 0; out_if.arready = 0;
      out_if.rvalid = 1; out_if.rdata = 32'hA5A5_0001; out_if.rlast = 1; out_if.rid = 4'h1; m0_if.rready = 1;
      settle();
      chk("t2_m0_rvalid", m0_if.rvalid, 1);
      chk("t2_m0_rdata", m0_if.rdata, 32'hA5A5_0001);
      chk("t2_m1_rvalid", m1_if.rvalid, 0);
      chk("t2_out_rready", out_if.rready, 1);
      step();
      out_if.rvalid = 0; out_if.rlast = 0; m0_if.rready = 0;
      settle();
      chk("t2_back_idle_rready", out_if.rready, 0);

      // T1: m1 read in data phase, then async reset
      m1_if.arvalid = 1; m1_if.araddr = 32'h600; m1_if.arlen = 3;
      step();
      chk("t1_m1_grant_addr", out_if.araddr, 32'h600);
      out_if.arready = 1;
      step();
      m1_if.arvalid = 0; out_if.arready = 0;
      out_if.rvalid = 1; out_if.rlast = 0; out_if.rdata = 32'h77; m1_if.rready = 1;
      settle();
      chk("t1_m1_rvalid_pre", m1_if.rvalid, 1);
      reset_n = 1'b0;
      settle();
      chk("t1_m1_rvalid_rst", m1_if.rvalid, 0);
      chk("t1_out_rready_rst", out_if.rready, 0);
      chk("t1_m1_rdata_rst", m1_if.rdata, 0);
      out_if.rvalid = 0; m1_if.rready = 0;
      step();
      reset_n = 1'b1;
      step();
      chk("t1_idle_after_rel", out_if.arvalid, 0);

      // T3: simultaneous len=3 reads, m0 wins after reset
      m0_if.arvalid = 1; m0_if.araddr = 32'h100; m0_if.arlen = 3;
      m1_if.arvalid = 1; m1_if.araddr = 32'h200; m1_if.arlen = 3;
      out_if.arready = 1;
      step();
      chk("t3_first_addr", out_if.araddr, 32'h100);
      chk("t3_first_len", out_if.arlen, 3);
      chk("t3_m1_arready_held", m1_if.arready, 0);
      step();
      m0_if.arvalid = 0;
      m0_if.rready = 1; m1_if.rready = 1; out_if.rvalid = 1;
      for (int i = 0; i < 4; i++) begin
         out_if.rdata = 32'h1000 + i; out_if.rlast = (i == 3);
         settle();
         chk("t3_m0_beat_valid", m0_if.rvalid, 1);
         chk("t3_m0_beat_data", m0_if.rdata, 32'h1000 + i);
         chk("t3_m1_no_rvalid", m1_if.rvalid, 0);
         step();
      end
      out_if.rvalid = 0; out_if.rlast = 0;
      settle();
      chk("t3_idle_gap", out_if.arvalid, 0);
      step();
      chk("t3_second_addr", out_if.araddr, 32'h200);
      chk("t3_m1_arready", m1_if.arready, 1);
      step();
      m1_if.arvalid = 0; out_if.rvalid = 1;
      for (int i = 0; i < 4; i++) begin
         out_if.rdata = 32'h2000 + i; out_if.rlast = (i == 3);
         settle();
         chk("t3_m1_beat_data", m1_if.rdata, 32'h2000 + i);
         chk("t3_m0_no_rvalid", m0_if.rvalid, 0);
         step();
      end
      out_if.rvalid = 0; out_if.rlast = 0;
      m0_if.arvalid = 1; m0_if.araddr = 32'h110; m0_if.arlen = 0;
      m1_if.arvalid = 1; m1_if.araddr = 32'h210; m1_if.arlen = 0;
      step();
      chk("t3_next_tie_m0", out_if.araddr, 32'h110);
      step();
      m0_if.arvalid = 0; out_if.arready = 0;
      out_if.rvalid = 1; out_if.rlast = 1; out_if.rdata = 32'h3;
      settle();
      chk("t3_tie_beat_m0", m0_if.rvalid, 1);
      step();
      out_if.rvalid = 0; out_if.rlast = 0; m1_if.arvalid = 0;
      m0_if.rready = 0; m1_if.rready = 0;
      step();

      // T4: m1 write len=1, W before AW, AW stalled 5 cycles
      m1_if.awvalid = 1; m1_if.awaddr = 32'h300; m1_if.awlen = 1; m1_if.awid = 4'h5;
      m1_if.wvalid = 1; m1_if.wdata = 32'h11; m1_if.wlast = 0;
      out_if.awready = 0; out_if.wready = 1;
      step();
      chk("t4_out_awvalid", out_if.awvalid, 1);
      chk("t4_out_awaddr", out_if.awaddr, 32'h300);
      chk("t4_out_wdata0", out_if.wdata, 32'h11);
      chk("t4_m1_wready", m1_if.wready, 1);
      chk("t4_m0_wready", m0_if.wready, 0);
      chk("t4_m1_awready_stall", m1_if.awready, 0);
      step();
      m1_if.wdata = 32'h22; m1_if.wlast = 1;
      settle();
      chk("t4_out_wdata1", out_if.wdata, 32'h22);
      chk("t4_out_wlast", out_if.wlast, 1);
      step();
      m1_if.wvalid = 0; m1_if.wlast = 0;
      chk("t4_wvalid_after_done", out_if.wvalid, 0);
      chk("t4_wready_after_done", m1_if.wready, 0);
      for (int i = 0; i < 3; i++) begin
         chk("t4_aw_still_pending", out_if.awvalid, 1);
         step();
      end
      out_if.awready = 1;
      settle();
      chk("t4_m1_awready", m1_if.awready, 1);
      step();
      m1_if.awvalid = 0; out_if.awready = 0;
      chk("t4_awvalid_after_done", out_if.awvalid, 0);
      out_if.bvalid = 1; out_if.bid = 4'h5; out_if.bresp = 2'b00; m1_if.bready = 1;
      settle();
      chk("t4_m1_bvalid", m1_if.bvalid, 1);
      chk("t4_m1_bid", m1_if.bid, 4'h5);
      chk("t4_m0_bvalid", m0_if.bvalid, 0);
      chk("t4_out_bready", out_if.bready, 1);
      step();
      out_if.bvalid = 0; m1_if.bready = 0;
      settle();
      chk("t4_single_b", m1_if.bvalid, 0);

      // T5: m0 read concurrent with m1 write
      m0_if.arvalid = 1; m0_if.araddr = 32'h400; m0_if.arlen = 0; m0_if.arid = 4'h2;
      m1_if.awvalid = 1; m1_if.awaddr = 32'h500; m1_if.awlen = 0; m1_if.awid = 4'h6;
      m1_if.wvalid = 1; m1_if.wdata = 32'h33; m1_if.wlast = 1;
      out_if.arready = 1; out_if.awready = 1; out_if.wready = 1;
      step();
      chk("t5_araddr", out_if.araddr, 32'h400);
      chk("t5_awaddr", out_if.awaddr, 32'h500);
      chk("t5_m0_arready", m0_if.arready, 1);
      chk("t5_m1_awready", m1_if.awready, 1);
      chk("t5_m1_wready", m1_if.wready, 1);
      step();
      m0_if.arvalid = 0; m1_if.awvalid = 0; m1_if.wvalid = 0; m1_if.wlast = 0;
      out_if.arready = 0; out_if.awready = 0; out_if.wready = 0;
      out_if.rvalid = 1; out_if.rlast = 1; out_if.rdata = 32'h44; out_if.rid = 4'h2;
      out_if.bvalid = 1; out_if.bid = 4'h6;
      m0_if.rready = 1; m1_if.rready = 1; m0_if.bready = 1; m1_if.bready = 1;
      settle();
      chk("t5_m0_rvalid", m0_if.rvalid, 1);
      chk("t5_m0_rdata", m0_if.rdata, 32'h44);
      chk("t5_m1_rvalid", m1_if.rvalid, 0);
      chk("t5_m1_bvalid", m1_if.bvalid, 1);
      chk("t5_m0_bvalid", m0_if.bvalid, 0);
      step();
      out_if.rvalid = 0; out_if.rlast = 0; out_if.bvalid = 0;
      settle();
      chk("t5_r_idle", out_if.rready, 0);
      chk("t5_b_idle", out_if.bready, 0);

      // T6: ID handling, m1 arid=3
      m1_if.arvalid = 1; m1_if.araddr = 32'h700; m1_if.arlen = 0; m1_if.arid = 4'h3;
      out_if.arready = 1;
      step();
`ifdef AXI4_ARB_ID_TAG_EN
      chk("t6_out_arid", out_if.arid, 4'hB);
`else
      chk("t6_out_arid", out_if.arid, 4'h3);
`endif
      step();
      m1_if.arvalid = 0; out_if.arready = 0;
`ifdef AXI4_ARB_ID_TAG_EN
      out_if.rid = 4'hB;
`else
      out_if.rid = 4'h3;
`endif
      out_if.rvalid = 1; out_if.rlast = 1; out_if.rdata = 32'h55;
      settle();
      chk("t6_m1_rvalid", m1_if.rvalid, 1);
      chk("t6_m1_rid", m1_if.rid, 4'h3);
      chk("t6_m0_rvalid", m0_if.rvalid, 0);
      step();
      out_if.rvalid = 0; out_if.rlast = 0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
